bin_to_ndigit_sevenseg_mux: RTL and testbench

Parametrised successor to the 4-digit binary-to-seven-segment driver: converts a BIN_WIDTH-bit unsigned value to NUM_DIGITS decimal or hex digits using a sequential double-dabble engine, then time-multiplexes them onto a shared active-low segment bus. It sits between the Fitbit counters (steps, distance, activity time) and the board's common-anode display. Over the 4-digit block it adds:
- an explicit conversion state machine
- leading-zero blanking
- a hex mode
- an overflow indication
- a display-off mode

---
 rtl/bin_to_ndigit_sevenseg_mux.sv | 196 +++++++++++++++++++
 tb/tb_bin_to_ndigit_sevenseg_mux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_ndigit_sevenseg_mux.sv
// Binary to NUM_DIGITS seven-segment driver: a free-running double-dabble converter feeds a
// display register that a refresh counter time-multiplexes onto an active-low segment bus.
// Optional decimal-point support is enabled with the macro SEVSEG_DP_EN.
module bin_to_ndigit_sevenseg_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [2:0]            MODE,
  input  logic [BIN_WIDTH-1:0]  binaryDigit,
`ifdef SEVSEG_DP_EN
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  decimalPoint,
`endif
  output logic                  conv_done,
  output logic [NUM_DIGITS-1:0] anodeSelect,
  output logic [6:0]            sevenSeg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int EXT_W = BCD_W + BIN_WIDTH;
  localparam int SC_W  = $clog2(BIN_WIDTH + 1);
  localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] M_DEC_BLANK = 2'd0;
  localparam logic [1:0] M_HEX       = 2'd2;
  localparam logic [1:0] M_OFF       = 2'd3;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] samp_val;
  logic [BIN_WIDTH-1:0] sh_val;
  logic [1:0]           samp_mode;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic                 ovf;
  logic [SC_W-1:0]      sh_cnt;
  logic [EXT_W-1:0]     hex_ext;
  logic                 hex_ovf;

  logic [BCD_W-1:0]     disp_dig;
  logic [1:0]           disp_mode;
  logic                 disp_ovf;

  logic [CW-1:0]        rcnt;
  logic [IW-1:0]        idx;
  logic [3:0]           cur_dig;
  logic                 higher_zero;
  logic [6:0]           glyph;

`ifdef SEVSEG_DP_EN
  logic [NUM_DIGITS-1:0] samp_dp;
  logic [NUM_DIGITS-1:0] disp_dp;
`endif

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    case (d)
      4'h0: glyph_of = 7'b1000000;
      4'h1: glyph_of = 7'b1111001;
      4'h2: glyph_of = 7'b0100100;
      4'h3: glyph_of = 7'b0110000;
      4'h4: glyph_of = 7'b0011001;
      4'h5: glyph_of = 7'b0010010;
      4'h6: glyph_of = 7'b0000010;
      4'h7: glyph_of = 7'b1111000;
      4'h8: glyph_of = 7'b0000000;
      4'h9: glyph_of = 7'b0010000;
      4'hA: glyph_of = 7'b0001000;
      4'hB: glyph_of = 7'b0000011;
      4'hC: glyph_of = 7'b1000110;
      4'hD: glyph_of = 7'b0100001;
      4'hE: glyph_of = 7'b0000110;
      default: glyph_of = 7'b0001110;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Hex digits come straight from the sampled value; anything above the top digit is overflow
  assign hex_ext = EXT_W'(samp_val);
  assign hex_ovf = |hex_ext[EXT_W-1:BCD_W];

  // Converter FSM: sample, shift BIN_WIDTH times, commit the frame atomically
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      samp_val  <= '0;
      sh_val    <= '0;
      samp_mode <= M_DEC_BLANK;
      bcd       <= '0;
      ovf       <= 1'b0;
      sh_cnt    <= '0;
      conv_done <= 1'b0;
      disp_dig  <= '0;
      disp_mode <= M_OFF;
      disp_ovf  <= 1'b0;
`ifdef SEVSEG_DP_EN
      samp_dp   <= '0;
      disp_dp   <= '0;
`endif
    end else begin
      conv_done <= 1'b0;
      case (state)
        S_IDLE: begin
          samp_val  <= binaryDigit;
          sh_val    <= binaryDigit;
          samp_mode <= MODE[2] ? M_DEC_BLANK : MODE[1:0];
          bcd       <= '0;
          ovf       <= 1'b0;
          sh_cnt    <= '0;
`ifdef SEVSEG_DP_EN
          samp_dp   <= dp_mask;
`endif
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          {bcd, sh_val} <= {bcd_adj[BCD_W-2:0], sh_val, 1'b0};
          ovf           <= ovf | bcd_adj[BCD_W-1];
          sh_cnt        <= sh_cnt + SC_W'(1);
          if (sh_cnt == SC_W'(BIN_WIDTH - 1)) begin
            state     <= S_COMMIT;
            conv_done <= 1'b1;
          end
        end
        S_COMMIT: begin
          disp_dig  <= (samp_mode == M_HEX) ? hex_ext[BCD_W-1:0] : bcd;
          disp_ovf  <= (samp_mode == M_HEX) ? hex_ovf : ovf;
          disp_mode <= samp_mode;
`ifdef SEVSEG_DP_EN
          disp_dp   <= samp_dp;
`endif
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Refresh counter and digit index; index steps on the terminal count
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      rcnt <= rcnt + CW'(1);
    end
  end

  // Glyph for the digit at the current index: dash on overflow, leading-zero blanking in mode 0
  always_comb begin
    cur_dig     = disp_dig[{idx, 2'b00} +: 4];
    higher_zero = ((disp_dig >> {idx, 2'b00}) == '0);
    glyph       = glyph_of(cur_dig);
    if (disp_ovf) glyph = SEG_DASH;
    else if (disp_mode == M_DEC_BLANK && idx != '0 && higher_zero) glyph = SEG_BLANK;
  end

  // Registered display outputs; mode 3 keeps every anode and segment dark
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      anodeSelect <= '1;
      sevenSeg    <= SEG_BLANK;
    end else if (disp_mode == M_OFF) begin
      anodeSelect <= '1;
      sevenSeg    <= SEG_BLANK;
    end else begin
      anodeSelect <= ~(NUM_DIGITS'(1) << idx);
      sevenSeg    <= glyph;
    end
  end

`ifdef SEVSEG_DP_EN
  // Decimal point follows the lit digit's committed mask bit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) decimalPoint <= 1'b1;
    else        decimalPoint <= (disp_mode == M_OFF) ? 1'b1 : ~disp_dp[idx];
  end
`endif

endmodule

// File: tb/tb_bin_to_ndigit_sevenseg_mux.sv
// Scoreboard bench for bin_to_ndigit_sevenseg_mux (4 digits, 14-bit input, refresh 4).
// Stimulus queues expected frames; a monitor checks one full digit rotation per frame.
module tb_bin_to_ndigit_sevenseg_mux;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G9 = 7'b0010000;
  localparam logic [6:0] GB = 7'b0000011, GC = 7'b1000110, GD = 7'b0100001;
  localparam logic [6:0] DASH = 7'b0111111, BLK = 7'h7F;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [2:0]    MODE = 3'd0;
  logic [BW-1:0] binaryDigit = 14'd234;
  logic          conv_done;
  logic [ND-1:0] anodeSelect;
  logic [6:0]    sevenSeg;
`ifdef SEVSEG_DP_EN
  logic [ND-1:0] dp_mask = '0;
  logic          decimalPoint;
`endif

  bin_to_ndigit_sevenseg_mux #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .MODE(MODE),
    .binaryDigit(binaryDigit),
`ifdef SEVSEG_DP_EN
    .dp_mask(dp_mask),
    .decimalPoint(decimalPoint),
`endif
    .conv_done(conv_done),
    .anodeSelect(anodeSelect),
    .sevenSeg(sevenSeg)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        off;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_f;
  bit     mon_busy = 1'b0;
  int     tests = 0;
  int     fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic frame_t lit(input logic [6:0] d3, input logic [6:0] d2,
                                 input logic [6:0] d1, input logic [6:0] d0);
    frame_t f;
    f.off  = 1'b0;
    f.segs = {d3, d2, d1, d0};
    return f;
  endfunction

  function automatic int anode_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Watch one full rotation of a lit frame, or a stretch of darkness for an off frame
  task automatic check_frame(input frame_t f);
    logic [3:0] prev;
    int hold, n, guard, ix;
    if (f.off) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        chk("off_anodes", {28'd0, anodeSelect}, 32'hF);
        chk("off_seg", {25'd0, sevenSeg}, 32'h7F);
      end
    end else begin
      prev = anodeSelect; hold = 0; n = 0; guard = 0;
      while (n < 4 && guard < 200) begin
        @(negedge CLK);
        guard++; hold++;
        if (anodeSelect !== prev) begin
          ix = anode_idx(anodeSelect);
          if (ix < 0) begin
            chk("anode_one_cold", {28'd0, anodeSelect}, 32'hE);
          end else begin
            if (n > 0) begin
              chk("anode_rotation", {28'd0, anodeSelect}, {28'd0, prev[2:0], prev[3]});
              chk("digit_hold", hold, 4);
            end
            chk($sformatf("digit%0d_seg", ix), {25'd0, sevenSeg}, {25'd0, f.segs[ix*7 +: 7]});
          end
          n++; hold = 0; prev = anodeSelect;
        end
      end
      if (n < 4) timeout("frame_rotation");
    end
  endtask

  // Monitor: pops an expected frame as soon as one is queued and checks it against the bus
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        mon_f = exp_q.pop_front();
        mon_busy = 1'b1;
        check_frame(mon_f);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_conv(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (conv_done !== 1'b1 && n < 100);
    if (conv_done !== 1'b1) timeout(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((exp_q.size() != 0 || mon_busy) && n < 400);
    if (exp_q.size() != 0 || mon_busy) timeout("scoreboard_drain");
  endtask

  // Apply inputs, let two commits pass so the frame is settled, then queue its expectation
  task automatic run_frame(input logic [2:0] m, input logic [BW-1:0] v, input frame_t f);
    @(negedge CLK);
    MODE = m;
    binaryDigit = v;
    wait_conv("conv_first");
    wait_conv("conv_second");
    @(negedge CLK);
    @(negedge CLK);
    exp_q.push_back(f);
    drain();
  endtask

  // Release reset at a falling edge and count rising edges until conv_done appears
  task automatic release_and_time(input string name);
    int cyc;
    @(negedge CLK);
    RESET = 1'b1;
    cyc = 0;
    do begin
      @(posedge CLK);
      #1;
      cyc++;
      if (cyc == 8) chk("dark_before_commit", {28'd0, anodeSelect}, 32'hF);
    end while (conv_done !== 1'b1 && cyc < 60);
    chk(name, cyc, 15);
    @(posedge CLK);
    #1;
    chk("conv_pulse_width", {31'd0, conv_done}, 32'd0);
  endtask

  initial begin
    int per;
    frame_t off_f;
    off_f.off = 1'b1;
    off_f.segs = '0;

    repeat (3) @(negedge CLK);
    chk("rst_anodes", {28'd0, anodeSelect}, 32'hF);
    chk("rst_seg", {25'd0, sevenSeg}, 32'h7F);
    chk("rst_conv_done", {31'd0, conv_done}, 32'd0);

    release_and_time("first_conv_cycle");

    wait_conv("period_a");
    per = 0;
    do begin
      @(negedge CLK);
      per++;
    end while (conv_done !== 1'b1 && per < 60);
    chk("conv_period", per, 16);

    run_frame(3'd0, 14'd234,   lit(BLK,  G2,   G3,   G4));
    run_frame(3'd1, 14'd234,   lit(G0,   G2,   G3,   G4));
    run_frame(3'd0, 14'd0,     lit(BLK,  BLK,  BLK,  G0));
    run_frame(3'd0, 14'd9999,  lit(G9,   G9,   G9,   G9));
    run_frame(3'd0, 14'd10000, lit(DASH, DASH, DASH, DASH));
    run_frame(3'd1, 14'd16383, lit(DASH, DASH, DASH, DASH));
    run_frame(3'd2, 14'h2BCD,  lit(G2,   GB,   GC,   GD));
    run_frame(3'd3, 14'h2BCD,  off_f);
    run_frame(3'd5, 14'd234,   lit(BLK,  G2,   G3,   G4));
    run_frame(3'd0, 14'd1005,  lit(G1,   G0,   G0,   G5));
    run_frame(3'd0, 14'd50,    lit(BLK,  BLK,  G5,   G0));

    // Reset in the middle of SHIFT: outputs clear immediately, timing restarts cleanly
    MODE = 3'd1;
    binaryDigit = 14'd234;
    wait_conv("pre_reset_conv");
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("midshift_rst_anodes", {28'd0, anodeSelect}, 32'hF);
    chk("midshift_rst_seg", {25'd0, sevenSeg}, 32'h7F);
    chk("midshift_rst_conv", {31'd0, conv_done}, 32'd0);
    repeat (3) @(negedge CLK);
    release_and_time("post_reset_conv_cycle");

    run_frame(3'd1, 14'd234, lit(G0, G2, G3, G4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
